piso_stream: RTL and testbench

//  Parametrised FIFO-buffered parallel-in/serial-out converter with ready/valid handshaking on both sides.

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_stream_bram_sdp.sv | 23 ++
 rtl/piso_stream.sv | 142 ++++++++++++++
 tb/tb_piso_stream.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_stream wide-to-narrow serialiser.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } state_t;

  function automatic int ratio(input int din_w, input int dout_w);
    return din_w / dout_w;
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // A single-lane word still needs a one-bit counter to keep the port widths legal.
  function automatic int lane_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/piso_stream_bram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port (1-clk latency).
// A same-address read and write on one edge returns the old contents.
module bram_sdp #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/piso_stream.sv
// FIFO-buffered parallel-in/serial-out converter with ready/valid on both sides.
// Optional: define PISO_FILL_LEVEL_EN to add the registered fill_level output.
module piso_stream
  import piso_pkg::*;
#(
  parameter int DIN_WIDTH  = 256,
  parameter int DOUT_WIDTH = 64,
  parameter int FIFO_DEPTH = 1024,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
`ifdef PISO_FILL_LEVEL_EN
  ,
  output logic [addr_w(FIFO_DEPTH):0] fill_level
`endif
);

  localparam int RATIO  = ratio(DIN_WIDTH, DOUT_WIDTH);
  localparam int ADDR_W = addr_w(FIFO_DEPTH);
  localparam int LANE_W = lane_w(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [ADDR_W:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  state_t                state_q, state_d;
  logic                  pf_vld_q, pf_vld_d;
  logic [LANE_W-1:0]     cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DIN_WIDTH-1:0]  pf_data;
  logic [DIN_WIDTH-1:0]  hold_q;
  logic                  we, re, load, xfer, is_last;
  int                    sel;
  logic [DOUT_WIDTH-1:0] lane;

  assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                 (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign din_ready = ~full;
  assign we        = din_valid & ~full;
  assign overflow  = ovf_q;

  bram_sdp #(
    .WIDTH(DIN_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_bram (
    .clk  (clk),
    .we   (we),
    .waddr(wptr_q[ADDR_W-1:0]),
    .wdata(din),
    .re   (re),
    .raddr(rptr_q[ADDR_W-1:0]),
    .rdata(pf_data)
  );

  assign dout_valid = (state_q == SHIFT);
  assign is_last    = (cnt_q == LAST_LANE);
  assign xfer       = dout_valid & dout_ready;

  // Reads start only once FETCH is entered, so the first word of a burst lands
  // three edges after it is written; afterwards the prefetch keeps SHIFT fed.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE:  if (!empty) state_d = FETCH;
      FETCH: if (pf_vld_q) begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (xfer && is_last) begin
        if (pf_vld_q)    load    = 1'b1;
        else if (!empty) state_d = FETCH;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    re = (state_q != IDLE) && !empty && (!pf_vld_q || load);
  end

  always_comb begin
    wptr_d   = we ? wptr_q + (ADDR_W+1)'(1) : wptr_q;
    rptr_d   = re ? rptr_q + (ADDR_W+1)'(1) : rptr_q;
    pf_vld_d = re ? 1'b1 : (load ? 1'b0 : pf_vld_q);
    ovf_d    = ovf_q | (din_valid & full);
    cnt_d    = cnt_q;
    if (xfer) cnt_d = is_last ? '0 : cnt_q + LANE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      state_q  <= IDLE;
      pf_vld_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      state_q  <= state_d;
      pf_vld_q <= pf_vld_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) hold_q <= pf_data;
  end

  // Lane mux; dout is forced to zero whenever no lane is being presented.
  always_comb begin
    sel  = (MSB_FIRST != 0) ? (RATIO - 1 - int'(cnt_q)) : int'(cnt_q);
    lane = hold_q[sel*DOUT_WIDTH +: DOUT_WIDTH];
  end

  assign dout      = dout_valid ? lane : '0;
  assign dout_last = dout_valid & is_last;

`ifdef PISO_FILL_LEVEL_EN
  logic [ADDR_W:0] fill_q;

  always_ff @(posedge clk) begin
    if (rst) fill_q <= '0;
    else     fill_q <= wptr_d - rptr_d;
  end

  assign fill_level = fill_q;
`endif

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench for piso_stream: 256->64 bit, 16-entry FIFO, LSB-first and MSB-first instances.
module tb_piso_stream;

  localparam int DIN   = 256;
  localparam int DOUT  = 64;
  localparam int DEPTH = 16;
  localparam int RATIO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [DIN-1:0]  din;
  logic            din_valid;
  logic            dout_ready;

  logic            l_din_ready, l_dout_valid, l_dout_last, l_full, l_empty, l_ovf;
  logic [DOUT-1:0] l_dout;
  logic            m_din_ready, m_dout_valid, m_dout_last, m_full, m_empty, m_ovf;
  logic [DOUT-1:0] m_dout;
`ifdef PISO_FILL_LEVEL_EN
  logic [4:0]      l_fill, m_fill;
`endif

  piso_stream #(.DIN_WIDTH(DIN), .DOUT_WIDTH(DOUT), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_din_ready),
    .dout(l_dout), .dout_valid(l_dout_valid), .dout_ready(dout_ready), .dout_last(l_dout_last),
    .full(l_full), .empty(l_empty), .overflow(l_ovf)
`ifdef PISO_FILL_LEVEL_EN
    , .fill_level(l_fill)
`endif
  );

  piso_stream #(.DIN_WIDTH(DIN), .DOUT_WIDTH(DOUT), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_din_ready),
    .dout(m_dout), .dout_valid(m_dout_valid), .dout_ready(dout_ready), .dout_last(m_dout_last),
    .full(m_full), .empty(m_empty), .overflow(m_ovf)
`ifdef PISO_FILL_LEVEL_EN
    , .fill_level(m_fill)
`endif
  );

  typedef struct packed {
    logic [DOUT-1:0] d;
    logic            l;
  } lane_t;

  lane_t q[$];
  lane_t e;
  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0, sel_msb = 1'b0, stab_en = 1'b0;
  int    run = 0, max_run = 0, xfers = 0;
  bit    prev_stall = 1'b0;
  logic [DOUT-1:0] prev_d;
  logic            prev_l;

  logic [DOUT-1:0] o_dout;
  logic            o_valid, o_last, o_din_ready;
  assign o_dout      = sel_msb ? m_dout       : l_dout;
  assign o_valid     = sel_msb ? m_dout_valid : l_dout_valid;
  assign o_last      = sel_msb ? m_dout_last  : l_dout_last;
  assign o_din_ready = sel_msb ? m_din_ready  : l_din_ready;

  localparam logic [DIN-1:0] W1 = {64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111};

  // Lane scoreboard, gap tracking and stall-stability checks, all on the falling edge.
  always @(negedge clk) begin
    if (mon_en && o_valid && dout_ready) begin
      total++;
      xfers++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL lane_extra: got dout=%h last=%b, no lane expected", o_dout, o_last);
      end else begin
        e = q.pop_front();
        if ({o_dout, o_last} !== {e.d, e.l}) begin
          bad++;
          $display("FAIL lane: got dout=%h last=%b, expected dout=%h last=%b",
                   o_dout, o_last, e.d, e.l);
        end
      end
    end
    if (o_valid) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (stab_en && prev_stall) begin
      total++;
      if (o_valid !== 1'b1 || o_dout !== prev_d || o_last !== prev_l) begin
        bad++;
        $display("FAIL stall_hold: got valid=%b dout=%h last=%b, expected valid=1 dout=%h last=%b",
                 o_valid, o_dout, o_last, prev_d, prev_l);
      end
    end
    prev_stall = o_valid && !dout_ready;
    prev_d     = o_dout;
    prev_l     = o_last;
  end

  task automatic push_word(input logic [DIN-1:0] w);
    lane_t t;
    int    idx;
    for (int i = 0; i < RATIO; i++) begin
      idx = sel_msb ? (RATIO - 1 - i) : i;
      t.d = w[idx*DOUT +: DOUT];
      t.l = (i == RATIO - 1);
      q.push_back(t);
    end
  endtask

  function automatic logic [DIN-1:0] rand_word();
    logic [DIN-1:0] w;
    for (int i = 0; i < DIN / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic drive_word(input logic [DIN-1:0] w);
    int n;
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!o_din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got din_ready=0 for 50 cycles, expected 1");
    end
    push_word(w);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    din        = '0;
    mon_en     = 1'b0;
    stab_en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d lanes outstanding, expected 0", name, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    total++;
    if ({l_din_ready, l_dout_valid, l_dout_last, l_full, l_empty, l_ovf} !== 6'b100010) begin
      bad++;
      $display("FAIL reset_flags_lsb: got %b, expected 100010",
               {l_din_ready, l_dout_valid, l_dout_last, l_full, l_empty, l_ovf});
    end
    total++;
    if (l_dout !== '0) begin
      bad++;
      $display("FAIL reset_dout_lsb: got %h, expected 0", l_dout);
    end
    total++;
    if ({m_din_ready, m_dout_valid, m_dout_last, m_full, m_empty, m_ovf} !== 6'b100010) begin
      bad++;
      $display("FAIL reset_flags_msb: got %b, expected 100010",
               {m_din_ready, m_dout_valid, m_dout_last, m_full, m_empty, m_ovf});
    end
    total++;
    if (m_dout !== '0) begin
      bad++;
      $display("FAIL reset_dout_msb: got %h, expected 0", m_dout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int cyc;
    reset_dut();
    dout_ready = 1'b1;
    mon_en     = 1'b1;
    drive_word(W1);
    din_valid = 1'b0;
    cyc = 0;
    while (!o_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 4) begin
      bad++;
      $display("FAIL single_latency: got first valid on falling edge %0d after accept, expected 4", cyc);
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    reset_dut();
    dout_ready = 1'b1;
    mon_en     = 1'b1;
    max_run    = 0;
    xfers      = 0;
    for (int i = 0; i < 8; i++) drive_word(rand_word());
    din_valid = 1'b0;
    wait_drain("b2b");
    total++;
    if (max_run !== 32) begin
      bad++;
      $display("FAIL b2b_gapless: got longest valid run %0d, expected 32", max_run);
    end
    total++;
    if (xfers !== 32) begin
      bad++;
      $display("FAIL b2b_count: got %0d lanes, expected 32", xfers);
    end
  endtask

  task automatic test_stall();
    int n;
    reset_dut();
    mon_en = 1'b1;
    xfers  = 0;
    drive_word(rand_word());
    drive_word(rand_word());
    din_valid = 1'b0;
    stab_en   = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      dout_ready = ~dout_ready;
      @(posedge clk);
      #1;
      n++;
    end
    dout_ready = 1'b1;
    wait_drain("stall");
    stab_en = 1'b0;
    total++;
    if (xfers !== 8) begin
      bad++;
      $display("FAIL stall_count: got %0d lanes, expected 8", xfers);
    end
  endtask

  task automatic test_fill();
    int acc;
    reset_dut();
    acc       = 0;
    din       = rand_word();
    din_valid = 1'b1;
    @(negedge clk);
    while (l_din_ready && acc < 40) begin
      acc++;
      @(negedge clk);
    end
    total++;
    if (acc !== 18) begin
      bad++;
      $display("FAIL fill_count: got %0d words accepted, expected 18", acc);
    end
    total++;
    if ({l_full, l_din_ready, l_ovf} !== 3'b100) begin
      bad++;
      $display("FAIL fill_flags: got full,ready,ovf=%b, expected 100", {l_full, l_din_ready, l_ovf});
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    total++;
    if (l_ovf !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got %b, expected 1", l_ovf);
    end
    repeat (5) @(negedge clk);
    total++;
    if ({l_ovf, l_full} !== 2'b11) begin
      bad++;
      $display("FAIL overflow_sticky: got ovf,full=%b, expected 11", {l_ovf, l_full});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [DIN-1:0] w2;
    reset_dut();
    mon_en = 1'b1;
    drive_word(W1);
    drive_word(rand_word());
    drive_word(rand_word());
    din_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({o_valid, o_dout, l_empty} !== {1'b1, W1[2*DOUT +: DOUT], 1'b0}) begin
      bad++;
      $display("FAIL mid_lane2: got valid=%b dout=%h empty=%b, expected valid=1 dout=%h empty=0",
               o_valid, o_dout, l_empty, W1[2*DOUT +: DOUT]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    total++;
    if ({l_dout_valid, l_empty, l_ovf, l_dout} !== {3'b010, {DOUT{1'b0}}}) begin
      bad++;
      $display("FAIL mid_reset: got valid,empty,ovf=%b dout=%h, expected 010 dout=0",
               {l_dout_valid, l_empty, l_ovf}, l_dout);
    end
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    w2 = rand_word();
    drive_word(w2);
    din_valid = 1'b0;
    wait_drain("mid_restart");
  endtask

  task automatic test_msb_first();
    reset_dut();
    sel_msb    = 1'b1;
    dout_ready = 1'b1;
    mon_en     = 1'b1;
    drive_word(W1);
    din_valid = 1'b0;
    wait_drain("msb");
    mon_en  = 1'b0;
    sel_msb = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fill();
    test_reset_mid();
    test_msb_first();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
